// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel front end and kernel.
// Contents: pixel width, pixel type and default image dimensions.
package sobel_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned IMG_W_DEF = 256;
    localparam int unsigned IMG_H_DEF = 256;

    typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/sobel_line_buf.sv
// Single-port line buffer, DEPTH x WIDTH, with read-before-write on the same address.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   addr   in   read/write address (column)
//   wdata  in   write data
//   rdata  out  combinational read of the addressed entry (old value during a write)
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH = IMG_W_DEF,
    parameter int unsigned WIDTH = PIX_W,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    // Never cleared; the row gate in the top level keeps stale contents out of windows.
    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster-to-3x3-neighbourhood front end for the Sobel kernel.
// Accepts one pixel per cycle in raster order, buffers two lines and emits the eight
// neighbours of every interior pixel one cycle after the bottom-right pixel is accepted.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pix_in/pix_valid    input pixel and its accept strobe (no backpressure)
//   pix_sof             start of frame, qualified by pix_valid; forces position (0,0)
//   win0..win7          neighbours TL, T, TR, L, R, BL, B, BR (held while win_valid low)
//   win_valid           new window this cycle
//   win_cx/win_cy       window centre coordinates
//   frame_done          pulse in the cycle after the last pixel of a frame is accepted
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    parameter int unsigned PIX_W = sobel_pkg::PIX_W,
    parameter int unsigned CW    = $clog2(IMG_W),
    parameter int unsigned RW    = $clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             pix_sof,
    output logic [PIX_W-1:0] win0,
    output logic [PIX_W-1:0] win1,
    output logic [PIX_W-1:0] win2,
    output logic [PIX_W-1:0] win3,
    output logic [PIX_W-1:0] win4,
    output logic [PIX_W-1:0] win5,
    output logic [PIX_W-1:0] win6,
    output logic [PIX_W-1:0] win7,
    output logic             win_valid,
    output logic [CW-1:0]    win_cx,
    output logic [RW-1:0]    win_cy,
    output logic             frame_done
);

    logic [CW-1:0]    x_q, x_cur;
    logic [RW-1:0]    y_q, y_cur;
    logic             last_col, last_row, emit;
    logic [PIX_W-1:0] lb1_rd, lb2_rd;

    // Older window columns: index 0 = row y-2, 1 = row y-1, 2 = row y.
    logic [PIX_W-1:0] col1_q [3];  // column x-1
    logic [PIX_W-1:0] col2_q [3];  // column x-2

    // SOF overrides the counters for the pixel it arrives with.
    always_comb begin
        x_cur    = pix_sof ? '0 : x_q;
        y_cur    = pix_sof ? '0 : y_q;
        last_col = (x_cur == CW'(IMG_W - 1));
        last_row = (y_cur == RW'(IMG_H - 1));
        emit     = pix_valid && (x_cur >= CW'(2)) && (y_cur >= RW'(2));
    end

    // LB2 takes LB1's old contents, LB1 takes the new pixel.
    sobel_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .AW    (CW)
    ) u_lb1 (
        .clk   (clk),
        .we    (pix_valid),
        .addr  (x_cur),
        .wdata (pix_in),
        .rdata (lb1_rd)
    );

    sobel_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .AW    (CW)
    ) u_lb2 (
        .clk   (clk),
        .we    (pix_valid),
        .addr  (x_cur),
        .wdata (lb1_rd),
        .rdata (lb2_rd)
    );

    // Shift register is not cleared across lines; the x >= 2 gate hides mixed columns.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            col2_q    <= col1_q;
            col1_q[0] <= lb2_rd;
            col1_q[1] <= lb1_rd;
            col1_q[2] <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win0       <= '0;
            win1       <= '0;
            win2       <= '0;
            win3       <= '0;
            win4       <= '0;
            win5       <= '0;
            win6       <= '0;
            win7       <= '0;
            win_cx     <= '0;
            win_cy     <= '0;
        end else begin
            win_valid  <= emit;
            frame_done <= pix_valid && last_col && last_row;

            if (pix_valid) begin
                if (last_col) begin
                    x_q <= '0;
                    y_q <= last_row ? '0 : y_cur + RW'(1);
                end else begin
                    x_q <= x_cur + CW'(1);
                    y_q <= y_cur;
                end
            end

            if (emit) begin
                win0   <= col2_q[0];
                win1   <= col1_q[0];
                win2   <= lb2_rd;
                win3   <= col2_q[1];
                win4   <= lb1_rd;
                win5   <= col2_q[2];
                win6   <= col1_q[2];
                win7   <= pix_in;
                win_cx <= x_cur - CW'(1);
                win_cy <= y_cur - RW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench: a 5x4 instance and a 3x3 instance are compared every cycle against a
// behavioural model that stores each frame as a 2-D image indexed by a linear pixel count.
module tb_sobel_window_gen;
    import sobel_pkg::*;

    localparam int W0 = 5;
    localparam int H0 = 4;
    localparam int W1 = 3;
    localparam int H1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [2];
    logic vld [2];
    logic sof [2];
    pix_t pix [2];

    pix_t       w0 [8];
    pix_t       w1 [8];
    logic       wv0, wv1, fd0, fd1;
    logic [2:0] cx0;
    logic [1:0] cy0, cx1, cy1;

    sobel_window_gen #(.IMG_W(W0), .IMG_H(H0)) dut0 (
        .clk(clk), .rst(rst[0]), .pix_in(pix[0]), .pix_valid(vld[0]), .pix_sof(sof[0]),
        .win0(w0[0]), .win1(w0[1]), .win2(w0[2]), .win3(w0[3]),
        .win4(w0[4]), .win5(w0[5]), .win6(w0[6]), .win7(w0[7]),
        .win_valid(wv0), .win_cx(cx0), .win_cy(cy0), .frame_done(fd0)
    );

    sobel_window_gen #(.IMG_W(W1), .IMG_H(H1)) dut1 (
        .clk(clk), .rst(rst[1]), .pix_in(pix[1]), .pix_valid(vld[1]), .pix_sof(sof[1]),
        .win0(w1[0]), .win1(w1[1]), .win2(w1[2]), .win3(w1[3]),
        .win4(w1[4]), .win5(w1[5]), .win6(w1[6]), .win7(w1[7]),
        .win_valid(wv1), .win_cx(cx1), .win_cy(cy1), .frame_done(fd1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    pix_t img [2][4][5];
    int   n_m [2];
    logic ev  [2];
    logic efd [2];
    pix_t ew  [2][8];
    int   ecx [2];
    int   ecy [2];

    task automatic model_step(input int d);
        int w, h, x, y;
        w = (d == 0) ? W0 : W1;
        h = (d == 0) ? H0 : H1;
        if (rst[d]) begin
            n_m[d] = 0; ev[d] = 0; efd[d] = 0; ecx[d] = 0; ecy[d] = 0;
            for (int k = 0; k < 8; k++) ew[d][k] = '0;
        end else begin
            ev[d]  = 0;
            efd[d] = 0;
            if (vld[d]) begin
                if (sof[d]) n_m[d] = 0;
                x = n_m[d] % w;
                y = n_m[d] / w;
                img[d][y][x] = pix[d];
                if (x >= 2 && y >= 2) begin
                    ev[d] = 1;
                    ew[d][0] = img[d][y-2][x-2];
                    ew[d][1] = img[d][y-2][x-1];
                    ew[d][2] = img[d][y-2][x];
                    ew[d][3] = img[d][y-1][x-2];
                    ew[d][4] = img[d][y-1][x];
                    ew[d][5] = img[d][y][x-2];
                    ew[d][6] = img[d][y][x-1];
                    ew[d][7] = img[d][y][x];
                    ecx[d] = x - 1;
                    ecy[d] = y - 1;
                end
                n_m[d]++;
                if (n_m[d] == w * h) begin
                    n_m[d] = 0;
                    efd[d] = 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) model_step(d);
    end

    // ---------------- compare process ----------------
    int          wcount [2];
    int          fdcount [2];
    int          coinc [2];
    logic [63:0] wq0 [$];
    logic [63:0] wq1 [$];
    int          cq0 [$];
    int          cq1 [$];

    task automatic compare_one(input int d, input logic v, input logic f, input int cx,
                               input int cy, input logic [63:0] wp);
        logic [63:0] ep;
        ep = {ew[d][0], ew[d][1], ew[d][2], ew[d][3], ew[d][4], ew[d][5], ew[d][6], ew[d][7]};
        chk($sformatf("dut%0d win_valid", d), {63'd0, v}, {63'd0, ev[d]});
        chk($sformatf("dut%0d frame_done", d), {63'd0, f}, {63'd0, efd[d]});
        chk($sformatf("dut%0d win_cx", d), 64'(cx), 64'(ecx[d]));
        chk($sformatf("dut%0d win_cy", d), 64'(cy), 64'(ecy[d]));
        chk($sformatf("dut%0d window", d), wp, ep);
        if (v === 1'b1) begin
            wcount[d]++;
            if (f === 1'b1) coinc[d]++;
            if (d == 0) begin wq0.push_back(wp); cq0.push_back(cx * 256 + cy); end
            else begin wq1.push_back(wp); cq1.push_back(cx * 256 + cy); end
        end
        if (f === 1'b1) fdcount[d]++;
    endtask

    always @(negedge clk) begin
        if (started) begin
            compare_one(0, wv0, fd0, int'(cx0), int'(cy0),
                        {w0[0], w0[1], w0[2], w0[3], w0[4], w0[5], w0[6], w0[7]});
            compare_one(1, wv1, fd1, int'(cx1), int'(cy1),
                        {w1[0], w1[1], w1[2], w1[3], w1[4], w1[5], w1[6], w1[7]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int d, input bit v, input bit s, input pix_t p);
        @(negedge clk);
        for (int e = 0; e < 2; e++) begin vld[e] = 1'b0; sof[e] = 1'b0; end
        vld[d] = v;
        sof[d] = s & v;
        pix[d] = p;
    endtask

    task automatic idle(input int nc);
        for (int i = 0; i < nc; i++) drive(0, 1'b0, 1'b0, '0);
    endtask

    task automatic feed(input int d, input int base, input bit sof_first, input bit rnd,
                        input int n_start, input int n_end);
        int w;
        w = (d == 0) ? W0 : W1;
        for (int n = n_start; n < n_end; n++) begin
            while (rnd && ($urandom_range(1, 0) == 1)) drive(d, 1'b0, 1'b0, '0);
            drive(d, 1'b1, sof_first && (n == n_start), pix_t'(base + 16 * (n / w) + n % w));
        end
        idle(3);
    endtask

    task automatic clear_stats();
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin wcount[d] = 0; fdcount[d] = 0; coinc[d] = 0; end
        wq0.delete(); wq1.delete(); cq0.delete(); cq1.delete();
    endtask

    task automatic check_dut0_zero(input string tag);
        chk({tag, " win_valid"}, {63'd0, wv0}, 64'd0);
        chk({tag, " frame_done"}, {63'd0, fd0}, 64'd0);
        chk({tag, " win_cx"}, {61'd0, cx0}, 64'd0);
        chk({tag, " win_cy"}, {62'd0, cy0}, 64'd0);
        chk({tag, " window"}, {w0[0], w0[1], w0[2], w0[3], w0[4], w0[5], w0[6], w0[7]}, 64'd0);
    endtask

    localparam logic [63:0] FirstWin  = 64'h00_01_02_10_12_20_21_22;
    localparam logic [63:0] LastWin   = 64'h12_13_14_22_24_32_33_34;
    localparam logic [63:0] FirstWin2 = 64'h80_81_82_90_92_a0_a1_a2;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; vld[d] = 1'b0; sof[d] = 1'b0; pix[d] = '0;
            wcount[d] = 0; fdcount[d] = 0; coinc[d] = 0;
        end
        #1;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        #1;
        started = 1'b1;
        check_dut0_zero("reset");
        chk("reset dut1 win_valid", {63'd0, wv1}, 64'd0);
        chk("reset dut1 window", {w1[0], w1[1], w1[2], w1[3], w1[4], w1[5], w1[6], w1[7]}, 64'd0);
        idle(3);
        @(negedge clk);
        #2;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Single frame, continuous
        clear_stats();
        feed(0, 8'h00, 1'b1, 1'b0, 0, W0 * H0);
        chk("t1 windows", 64'(wcount[0]), 64'd6);
        chk("t1 frame_done", 64'(fdcount[0]), 64'd1);
        chk("t1 first window", wq0[0], FirstWin);
        chk("t1 first centre", 64'(cq0[0]), 64'h101);
        chk("t1 last window", wq0[5], LastWin);
        chk("t1 last centre", 64'(cq0[5]), 64'h302);

        // Same frame, random 50% valid duty
        clear_stats();
        feed(0, 8'h00, 1'b1, 1'b1, 0, W0 * H0);
        chk("t2 windows", 64'(wcount[0]), 64'd6);
        chk("t2 frame_done", 64'(fdcount[0]), 64'd1);
        chk("t2 first window", wq0[0], FirstWin);
        chk("t2 last window", wq0[5], LastWin);

        // Two back-to-back frames, second without SOF (natural wrap)
        clear_stats();
        feed(0, 8'h00, 1'b1, 1'b0, 0, W0 * H0);
        feed(0, 8'h80, 1'b0, 1'b1, 0, W0 * H0);
        chk("t3 windows", 64'(wcount[0]), 64'd12);
        chk("t3 frame_done", 64'(fdcount[0]), 64'd2);
        chk("t3 frame2 first window", wq0[6], FirstWin2);

        // SOF re-asserted at (1,2) of frame 1
        clear_stats();
        feed(0, 8'h00, 1'b1, 1'b0, 0, 2 * W0 + 1);
        feed(0, 8'h80, 1'b1, 1'b0, 0, 2 * W0 + 2);
        chk("t4 no early window", 64'(wcount[0]), 64'd0);
        feed(0, 8'h80, 1'b0, 1'b0, 2 * W0 + 2, W0 * H0);
        chk("t4 windows", 64'(wcount[0]), 64'd6);
        chk("t4 frame_done", 64'(fdcount[0]), 64'd1);
        chk("t4 first window", wq0[0], FirstWin2);

        // Reset mid row 2, restart without SOF
        clear_stats();
        feed(0, 8'h40, 1'b1, 1'b0, 0, 2 * W0 + 4);
        @(negedge clk);
        vld[0] = 1'b0;
        #2;
        rst[0] = 1'b1;
        #1;
        check_dut0_zero("t5 in reset");
        idle(2);
        @(negedge clk);
        #2;
        rst[0] = 1'b0;
        clear_stats();
        feed(0, 8'h00, 1'b0, 1'b1, 0, W0 * H0);
        chk("t5 windows", 64'(wcount[0]), 64'd6);
        chk("t5 frame_done", 64'(fdcount[0]), 64'd1);
        chk("t5 first window", wq0[0], FirstWin);
        chk("t5 last window", wq0[5], LastWin);

        // Minimum 3x3 image
        clear_stats();
        feed(1, 8'h00, 1'b1, 1'b0, 0, W1 * H1);
        chk("t6 windows", 64'(wcount[1]), 64'd1);
        chk("t6 frame_done", 64'(fdcount[1]), 64'd1);
        chk("t6 coincident", 64'(coinc[1]), 64'd1);
        chk("t6 window", wq1[0], FirstWin);
        chk("t6 centre", 64'(cq1[0]), 64'h101);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
